mont_mult: RTL and testbench

MONT_MULT -- requirements
Module: mont_mult

---
 rtl/mont_mult.sv | 102 ++++++++++
 tb/tb_mont_mult.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mont_mult.sv
// Radix-2 bit-serial Montgomery multiplier: out = a*b*2^-BITS mod n.
// Latency BITS+2 cycles from accept to out_valid; no input accepted while busy (ready=0).
module mont_mult #(
  parameter int BITS = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [BITS-1:0] a,
  input  logic [BITS-1:0] b,
  input  logic [BITS-1:0] n,
  output logic            ready,
  output logic            out_valid,
  output logic [BITS-1:0] out
);

  localparam int CW = (BITS > 1) ? $clog2(BITS) : 1;

  typedef enum logic [1:0] {IDLE, LOOP, REDUCE, DONE} state_t;

  state_t            r_state;
  logic [BITS-1:0]   r_a;
  logic [BITS-1:0]   r_b;
  logic [BITS-1:0]   r_n;
  logic [BITS-1:0]   r_out;
  logic [BITS+1:0]   r_s;
  logic [CW-1:0]     r_cnt;
  logic              r_ready;
  logic              r_out_valid;

  logic [BITS+1:0]   w_add_b;
  logic [BITS+1:0]   w_add_n;
  logic [BITS+1:0]   w_s_next;
  logic [BITS-1:0]   w_s_sub;

  // S stays below 2n, so S + b + n stays below 4n and fits BITS+2 bits.
  always_comb begin
    w_add_b  = r_s + (r_a[0] ? {2'b00, r_b} : '0);
    w_add_n  = w_add_b + (w_add_b[0] ? {2'b00, r_n} : '0);
    w_s_next = w_add_n >> 1;
    w_s_sub  = r_s[BITS-1:0] - r_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_n         <= '0;
      r_out       <= '0;
      r_s         <= '0;
      r_cnt       <= '0;
      r_ready     <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= b;
            r_n     <= n;
            r_s     <= '0;
            r_cnt   <= '0;
            r_ready <= 1'b0;
            r_state <= LOOP;
          end
        end
        LOOP: begin
          // r_a shifts right so bit i of the multiplicand is always at r_a[0]
          r_s   <= w_s_next;
          r_a   <= r_a >> 1;
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == CW'(BITS - 1)) begin
            r_state <= REDUCE;
          end
        end
        REDUCE: begin
          if (r_s >= {2'b00, r_n}) begin
            r_out <= w_s_sub;
          end else begin
            r_out <= r_s[BITS-1:0];
          end
          r_out_valid <= 1'b1;
          r_state     <= DONE;
        end
        DONE: begin
          r_out_valid <= 1'b0;
          r_ready     <= 1'b1;
          r_state     <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign ready     = r_ready;
  assign out_valid = r_out_valid;
  assign out       = r_out;

endmodule

// File: tb/tb_mont_mult.sv
// Bench for mont_mult: known vectors, multi-cycle corner sequences and random regression.
module tb_mont_mult;

  localparam int BITS = 64;
  localparam int LAT  = BITS + 2;
  localparam int PER  = BITS + 3;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic [BITS-1:0] va = '0;
  logic [BITS-1:0] vb = '0;
  logic [BITS-1:0] vn = 64'd3;
  logic            ready;
  logic            out_valid;
  logic [BITS-1:0] out;

  int total = 0;
  int bad   = 0;

  mont_mult #(.BITS(BITS)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .a        (va),
    .b        (vb),
    .n        (vn),
    .ready    (ready),
    .out_valid(out_valid),
    .out      (out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] n;
    logic [63:0] exp;
  } vec_t;

  // Multiply a*b by the inverse of 2 (i.e. (n+1)/2) BITS times, all mod n.
  function automatic logic [63:0] model(input logic [63:0] ma, input logic [63:0] mb,
                                        input logic [63:0] mn);
    logic [127:0] t;
    logic [127:0] h;
    logic [127:0] nn;
    nn = {64'd0, mn};
    t  = ({64'd0, ma} * {64'd0, mb}) % nn;
    h  = (nn + 128'd1) >> 1;
    for (int k = 0; k < BITS; k++) t = (t * h) % nn;
    return t[63:0];
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Accept one request (ready must be 1) and follow it to its result cycle.
  task automatic run_op(input string nm, input logic [63:0] ta, input logic [63:0] tb_,
                        input logic [63:0] tn, input logic [63:0] exp);
    int lat;
    int rdy_bad;
    va = ta; vb = tb_; vn = tn; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    va = rnd64(); vb = rnd64(); vn = rnd64();
    lat = 1;
    rdy_bad = 0;
    while (!out_valid && lat < LAT + 20) begin
      if (ready) rdy_bad++;
      tick();
      lat++;
    end
    check({nm, " latency"}, 64'(lat), 64'(LAT));
    check({nm, " out"}, out, exp);
    check({nm, " ready low while busy"}, 64'(rdy_bad), 64'd0);
    tick();
    check({nm, " pulse width"}, {63'd0, out_valid}, 64'd0);
    check({nm, " ready back"}, {63'd0, ready}, 64'd1);
  endtask

  vec_t tbl[8];

  initial begin
    int pulses;
    int pcyc;
    int rdy_bad;
    logic [63:0] pout;
    logic [63:0] exp0;
    logic [63:0] ca[3];
    logic [63:0] cb[3];
    logic [63:0] cn;
    logic [63:0] rc[3];
    logic [63:0] ro[3];
    int cnt;
    int idx;
    logic acc;
    logic [63:0] last;

    tbl[0] = '{64'd118772121022040735, 64'd1, 64'd4292017463532640823, 64'd1278674219578988324};
    tbl[1] = '{64'd5, 64'd1278674219578988324, 64'd4292017463532640823, 64'd5};
    tbl[2] = '{64'd0, 64'd12345, 64'd4292017463532640823, 64'd0};
    tbl[3] = '{64'd7, 64'd0, 64'd11, 64'd0};
    tbl[4] = '{64'd2, 64'd2, 64'd3, 64'd1};
    tbl[5] = '{64'd3, 64'd4, 64'd5, 64'd2};
    tbl[6] = '{64'd3, 64'd5, 64'd7, 64'd4};
    tbl[7] = '{64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1};

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("reset ready", {63'd0, ready}, 64'd1);
    check("reset out_valid", {63'd0, out_valid}, 64'd0);
    check("reset out", out, 64'd0);

    // Reset wins over a same-cycle request
    rst = 1'b1; in_valid = 1'b1; va = 64'd2; vb = 64'd2; vn = 64'd3;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    tick();
    check("rst priority ready", {63'd0, ready}, 64'd1);

    for (int i = 0; i < 8; i++) begin
      run_op($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].n, tbl[i].exp);
    end

    // Requests while busy are dropped; a/b/n changes do not disturb the op
    cn = 64'd4292017463532640823;
    exp0 = model(64'd123456789, 64'd987654321, cn);
    va = 64'd123456789; vb = 64'd987654321; vn = cn; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    pulses = 0; pcyc = 0; rdy_bad = 0; pout = '0;
    for (int c = 1; c <= LAT + 8; c++) begin
      if (out_valid) begin pulses++; pcyc = c; pout = out; end
      if (c <= LAT && ready) rdy_bad++;
      in_valid = (c == 10 || c == 40);
      va = rnd64() % cn; vb = rnd64() % cn;
      tick();
    end
    in_valid = 1'b0;
    check("busy pulses", 64'(pulses), 64'd1);
    check("busy pulse cycle", 64'(pcyc), 64'(LAT));
    check("busy result", pout, exp0);
    check("busy ready low", 64'(rdy_bad), 64'd0);

    // Reset in the middle of an operation
    va = 64'd42; vb = 64'd17; vn = 64'd1000003; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int c = 1; c < 30; c++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort ready", {63'd0, ready}, 64'd1);
    check("abort out", out, 64'd0);
    pulses = 0;
    for (int c = 0; c < LAT + 10; c++) begin
      if (out_valid) pulses++;
      tick();
    end
    check("abort pulses", 64'(pulses), 64'd0);
    run_op("after abort", 64'd42, 64'd17, 64'd1000003, model(64'd42, 64'd17, 64'd1000003));

    // in_valid held high across three back-to-back requests
    cn = 64'hC000_0000_0000_0001 + 64'(2 * $urandom_range(1000, 1));
    for (int k = 0; k < 3; k++) begin
      ca[k] = rnd64() % cn; cb[k] = rnd64() % cn;
      rc[k] = '0; ro[k] = '0;
    end
    cnt = 0; idx = 0;
    va = ca[0]; vb = cb[0]; vn = cn; in_valid = 1'b1;
    for (int c = 0; c < 3 * PER + 5; c++) begin
      acc = ready && in_valid;
      if (out_valid && cnt < 3) begin rc[cnt] = 64'(c); ro[cnt] = out; cnt++; end
      tick();
      if (acc) begin
        idx++;
        if (idx < 3) begin va = ca[idx]; vb = cb[idx]; end
        else in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    check("stream count", 64'(cnt), 64'd3);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("stream%0d cycle", k), rc[k], 64'(LAT + k * PER));
      check($sformatf("stream%0d out", k), ro[k], model(ca[k], cb[k], cn));
    end

    // Result holds while idle
    last = model(ca[2], cb[2], cn);
    for (int c = 0; c < 5; c++) tick();
    check("hold out", out, last);
    check("hold ready", {63'd0, ready}, 64'd1);

    // Random regression
    for (int i = 0; i < 600; i++) begin
      logic [63:0] rn;
      logic [63:0] ra;
      logic [63:0] rb;
      if (i % 4 == 0) rn = 64'($urandom_range(32'hFFFF, 3)) | 64'd1;
      else rn = rnd64() | 64'd1;
      if (rn == 64'd1) rn = 64'd3;
      ra = (i % 50 == 7) ? 64'd0 : rnd64() % rn;
      rb = (i % 50 == 9) ? rn - 64'd1 : rnd64() % rn;
      run_op($sformatf("rand%0d", i), ra, rb, rn, model(ra, rb, rn));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
